// File: rtl/utemporal_row_mac.sv
// Weight-stationary row of WIDTH temporal (unary-in-time) MAC columns.
// Each ifm operand is turned into N = |ifm| >> sh run cycles. In every run
// cycle, each column adds +/-(weight << sh) to its own saturating accumulator.
module utemporal_row_mac #(
    parameter int WIDTH  = 14,
    parameter int IWIDTH = 8,
    parameter int OWIDTH = 16,
    parameter int PWIDTH = 3
) (
    input  logic                                  clk,
    input  logic                                  rst,
    input  logic                                  w_load,
    input  logic [WIDTH-1:0]                      wght_sign,
    input  logic [WIDTH-1:0][IWIDTH-2:0]          wght_abs,
    input  logic [PWIDTH-1:0]                     prec,
    input  logic                                  in_valid,
    input  logic                                  in_last,
    input  logic signed [IWIDTH-1:0]              ifm,
    output logic                                  in_ready,
    input  logic                                  acc_clr,
    output logic                                  busy,
    output logic                                  out_valid,
    output logic signed [WIDTH-1:0][OWIDTH-1:0]   ofm,
    output logic [WIDTH-1:0]                      sat
);

    localparam int MW = IWIDTH - 1;                       // magnitude width
    localparam int SW = $clog2(IWIDTH);                   // shift amount width
    // Extended width for the saturating add; it is wide enough that the add cannot wrap
    localparam int EW = ((OWIDTH > 2 * MW + 1) ? OWIDTH : 2 * MW + 1) + 1;

    localparam logic [PWIDTH-1:0]     PMAX = PWIDTH'(MW);
    localparam logic [IWIDTH-1:0]     IMIN = {1'b1, {MW{1'b0}}};
    localparam logic signed [EW-1:0]  SMAX = {{(EW - OWIDTH + 1){1'b0}}, {(OWIDTH - 1){1'b1}}};
    localparam logic signed [EW-1:0]  SMIN = ~SMAX;

    typedef enum logic [1:0] {IDLE = 2'd0, RUN = 2'd1, DONE = 2'd2} state_t;

    // Returns {clipped, new_acc} for one signed-magnitude step acc +/- (w << sh).
    function automatic logic [OWIDTH:0] sat_add(
        input logic [OWIDTH-1:0] acc,
        input logic [MW-1:0]     w,
        input logic [SW-1:0]     sh,
        input logic              neg
    );
        logic signed [EW-1:0] a;
        logic signed [EW-1:0] d;
        logic signed [EW-1:0] s;
        a = EW'($signed(acc));
        d = EW'(w) << sh;
        if (neg) begin
            d = -d;
        end
        s = a + d;
        if (s > SMAX) begin
            return {1'b1, SMAX[OWIDTH-1:0]};
        end else if (s < SMIN) begin
            return {1'b1, SMIN[OWIDTH-1:0]};
        end else begin
            return {1'b0, s[OWIDTH-1:0]};
        end
    endfunction

    state_t                          state;
    state_t                          state_next;
    logic [MW-1:0]                   cnt;
    logic                            neg_ifm;
    logic [SW-1:0]                   sh_lat;
    logic                            last_lat;
    logic [WIDTH-1:0]                w_sign;
    logic [WIDTH-1:0][MW-1:0]        w_abs;
    logic [WIDTH-1:0][OWIDTH-1:0]    acc;
    logic [WIDTH-1:0]                sat_flag;

    logic [PWIDTH-1:0]               prec_eff;
    logic [SW-1:0]                   sh_in;
    logic [IWIDTH-1:0]               ifm_neg;
    logic [MW-1:0]                   mag_in;
    logic [MW-1:0]                   n_in;
    logic [WIDTH-1:0][OWIDTH-1:0]    acc_sum;
    logic [WIDTH-1:0]                acc_clip;

    // Operand decode: legalise prec, clamp |ifm| to the magnitude range, and derive the run length
    always_comb begin
        prec_eff = ((prec == {PWIDTH{1'b0}}) || (prec > PMAX)) ? PMAX : prec;
        sh_in    = SW'(MW) - SW'(prec_eff);
        ifm_neg  = {IWIDTH{1'b0}} - ifm;
        if (ifm == IMIN) begin
            mag_in = {MW{1'b1}};
        end else if (ifm[IWIDTH-1]) begin
            mag_in = ifm_neg[MW-1:0];
        end else begin
            mag_in = ifm[MW-1:0];
        end
        n_in = mag_in >> sh_in;
    end

    // Per-column saturating step values applied on each RUN cycle
    always_comb begin
        acc_sum  = '0;
        acc_clip = '0;
        for (int c = 0; c < WIDTH; c++) begin
            {acc_clip[c], acc_sum[c]} = sat_add(acc[c], w_abs[c], sh_lat, neg_ifm ^ w_sign[c]);
        end
    end

    // FSM state register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // FSM next state and status outputs
    always_comb begin
        state_next = state;
        in_ready   = 1'b0;
        busy       = 1'b0;
        out_valid  = 1'b0;
        case (state)
            IDLE: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    if (n_in != {MW{1'b0}}) begin
                        state_next = RUN;
                    end else if (in_last) begin
                        state_next = DONE;
                    end else begin
                        state_next = IDLE;
                    end
                end else begin
                    state_next = IDLE;
                end
            end
            RUN: begin
                busy = 1'b1;
                if (cnt <= MW'(1)) begin
                    state_next = last_lat ? DONE : IDLE;
                end else begin
                    state_next = RUN;
                end
            end
            DONE: begin
                out_valid  = 1'b1;
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // Datapath: weight/clear handling outside RUN, operand latch on transfer, accumulation in RUN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt      <= {MW{1'b0}};
            neg_ifm  <= 1'b0;
            sh_lat   <= {SW{1'b0}};
            last_lat <= 1'b0;
            w_sign   <= '0;
            w_abs    <= '0;
            acc      <= '0;
            sat_flag <= '0;
        end else if (state == RUN) begin
            cnt <= cnt - MW'(1);
            for (int c = 0; c < WIDTH; c++) begin
                acc[c] <= acc_sum[c];
                if (acc_clip[c]) begin
                    sat_flag[c] <= 1'b1;
                end
            end
        end else begin
            if (w_load) begin
                w_sign <= wght_sign;
                w_abs  <= wght_abs;
            end
            if (acc_clr) begin
                acc      <= '0;
                sat_flag <= '0;
            end
            if ((state == IDLE) && in_valid) begin
                cnt      <= n_in;
                neg_ifm  <= ifm[IWIDTH-1];
                sh_lat   <= sh_in;
                last_lat <= in_last;
            end
        end
    end

    assign ofm = acc;
    assign sat = sat_flag;

endmodule

// File: tb/tb_utemporal_row_mac.sv
// Self-checking bench for utemporal_row_mac: directed cases plus randomized
// operands checked against an arithmetic reference model of the row.
module tb_utemporal_row_mac;

    localparam int W = 14;

    logic                  clk = 1'b0;
    logic                  rst = 1'b1;
    logic                  w_load = 1'b0;
    logic [W-1:0]          wght_sign = '0;
    logic [W-1:0][6:0]     wght_abs = '0;
    logic [2:0]            prec = 3'd0;
    logic                  in_valid = 1'b0;
    logic                  in_last = 1'b0;
    logic signed [7:0]     ifm = 8'sd0;
    logic                  in_ready;
    logic                  acc_clr = 1'b0;
    logic                  busy;
    logic                  out_valid;
    logic [W-1:0][15:0]    ofm;
    logic [W-1:0]          sat;

    int checks = 0;
    int errors = 0;

    // Reference model state
    int m_acc[W];
    bit m_sat[W];
    bit m_ws[W];
    int m_wa[W];

    utemporal_row_mac #(.WIDTH(W), .IWIDTH(8), .OWIDTH(16), .PWIDTH(3)) dut (
        .clk(clk), .rst(rst), .w_load(w_load), .wght_sign(wght_sign),
        .wght_abs(wght_abs), .prec(prec), .in_valid(in_valid), .in_last(in_last),
        .ifm(ifm), .in_ready(in_ready), .acc_clr(acc_clr), .busy(busy),
        .out_valid(out_valid), .ofm(ofm), .sat(sat)
    );

    // Free-running clock
    always #5 clk = ~clk;

    task automatic chk(input string tag, input longint got, input longint exp);
        checks++;
        if (got != exp) begin
            errors++;
            $display("FAIL %s got %0d expected %0d", tag, got, exp);
        end
    endtask

    function automatic int col_ofm(input int c);
        return int'($signed(ofm[c]));
    endfunction

    task automatic check_cols(input string tag);
        for (int c = 0; c < W; c++) begin
            chk($sformatf("%s ofm%0d", tag, c), col_ofm(c), m_acc[c]);
            chk($sformatf("%s sat%0d", tag, c), sat[c], m_sat[c]);
        end
    endtask

    task automatic model_reset();
        for (int c = 0; c < W; c++) begin
            m_acc[c] = 0; m_sat[c] = 0; m_ws[c] = 0; m_wa[c] = 0;
        end
    endtask

    task automatic model_clear();
        for (int c = 0; c < W; c++) begin
            m_acc[c] = 0; m_sat[c] = 0;
        end
    endtask

    task automatic model_load();
        for (int c = 0; c < W; c++) begin
            m_ws[c] = wght_sign[c]; m_wa[c] = int'(wght_abs[c]);
        end
    endtask

    function automatic int run_len(input int x, input int p);
        int pe, mag;
        pe  = (p == 0 || p > 7) ? 7 : p;
        mag = (x == -128) ? 127 : ((x < 0) ? -x : x);
        return mag >> (7 - pe);
    endfunction

    // acc += sign * ((|ifm| >> sh) << sh) * |w|, saturated to 16-bit signed
    task automatic model_op(input int x, input int p);
        int pe, sh, mag, trunc, prod, t;
        pe    = (p == 0 || p > 7) ? 7 : p;
        sh    = 7 - pe;
        mag   = (x == -128) ? 127 : ((x < 0) ? -x : x);
        trunc = (mag >> sh) << sh;
        for (int c = 0; c < W; c++) begin
            prod = trunc * m_wa[c];
            if ((x < 0) != m_ws[c]) prod = -prod;
            t = m_acc[c] + prod;
            if (t > 32767) begin
                t = 32767; m_sat[c] = 1;
            end else if (t < -32768) begin
                t = -32768; m_sat[c] = 1;
            end
            m_acc[c] = t;
        end
    endtask

    task automatic rand_w();
        for (int c = 0; c < W; c++) begin
            wght_sign[c] = 1'($urandom_range(0, 1));
            wght_abs[c]  = 7'($urandom_range(0, 127));
        end
    endtask

    task automatic zero_w();
        wght_sign = '0;
        wght_abs  = '0;
    endtask

    // Offer one operand, then track busy/out_valid timing until the row is idle again.
    // disturb=1 pulses w_load (with new port weights) and acc_clr during RUN.
    task automatic send_op(input int x, input int p, input bit last, input bit clr,
                           input bit wl, input bit disturb, input string tag);
        int n, nbusy, lat, k;
        bit overlap;
        n = run_len(x, p);
        @(negedge clk);
        chk({tag, " ready"}, in_ready, 1);
        ifm = x[7:0]; prec = p[2:0]; in_last = last; in_valid = 1'b1;
        acc_clr = clr; w_load = wl;
        if (clr) model_clear();
        if (wl) model_load();
        model_op(x, p);
        @(negedge clk);
        in_valid = 1'b0; in_last = 1'b0; acc_clr = 1'b0; w_load = 1'b0;
        nbusy = 0; lat = 0; overlap = 0; k = 1;
        while (k < 300) begin
            if (busy) nbusy++;
            if (busy && in_ready) overlap = 1;
            if (out_valid) lat = (lat == 0) ? k : -1;
            if (disturb && k == 2) begin
                acc_clr = 1'b1; w_load = 1'b1; rand_w();
            end else begin
                acc_clr = 1'b0; w_load = 1'b0;
            end
            if (!busy && !out_valid) break;
            @(negedge clk);
            k++;
        end
        acc_clr = 1'b0; w_load = 1'b0;
        chk({tag, " timeout"}, (k < 300) ? 1 : 0, 1);
        chk({tag, " busy_cycles"}, nbusy, n);
        chk({tag, " out_valid_latency"}, lat, last ? n + 1 : 0);
        chk({tag, " ready_during_run"}, overlap, 0);
        check_cols(tag);
    endtask

    initial begin
        int x, p;
        model_reset();
        repeat (2) @(negedge clk);
        chk("reset busy", busy, 0);
        chk("reset out_valid", out_valid, 0);
        chk("reset in_ready", in_ready, 1);
        check_cols("reset");
        rst = 1'b0;

        // col0 +3, col1 -5, ifm +4 last
        zero_w();
        wght_abs[0] = 7'd3;
        wght_sign[1] = 1'b1; wght_abs[1] = 7'd5;
        send_op(4, 7, 1'b1, 1'b1, 1'b1, 1'b0, "basic");
        chk("basic ofm0 const", col_ofm(0), 12);
        chk("basic ofm1 const", col_ofm(1), -20);

        // Two operands, single result
        zero_w();
        wght_abs[0] = 7'd10;
        send_op(2, 7, 1'b0, 1'b1, 1'b1, 1'b0, "two_a");
        send_op(-3, 7, 1'b1, 1'b0, 1'b0, 1'b0, "two_b");
        chk("two ofm0 const", col_ofm(0), -10);

        // -128 clamp and saturation
        zero_w();
        wght_abs[0] = 7'd127;
        send_op(-128, 7, 1'b1, 1'b1, 1'b1, 1'b0, "clamp1");
        chk("clamp ofm0 const", col_ofm(0), -16129);
        chk("clamp sat0 const", sat[0], 0);
        send_op(-128, 7, 1'b1, 1'b0, 1'b0, 1'b0, "clamp2");
        send_op(-128, 7, 1'b1, 1'b0, 1'b0, 1'b0, "clamp3");
        chk("sat ofm0 const", col_ofm(0), -32768);
        chk("sat sat0 const", sat[0], 1);

        // Reduced precision
        zero_w();
        wght_abs[0] = 7'd1;
        send_op(100, 3, 1'b1, 1'b1, 1'b1, 1'b0, "prec3");
        chk("prec3 ofm0 const", col_ofm(0), 96);

        // Zero operand: no run, result next cycle, ofm unchanged
        send_op(0, 7, 1'b1, 1'b0, 1'b0, 1'b0, "zero");
        chk("zero ofm0 const", col_ofm(0), 96);

        // prec=0 is treated as full precision
        send_op(5, 0, 1'b1, 1'b1, 1'b0, 1'b0, "prec0");

        // w_load / acc_clr during RUN are ignored
        rand_w();
        send_op(20, 7, 1'b1, 1'b1, 1'b1, 1'b1, "disturb");

        // Asynchronous reset in the middle of a run
        rand_w();
        send_op(50, 7, 1'b0, 1'b1, 1'b1, 1'b0, "pre_rst");
        @(negedge clk);
        ifm = 8'sd10; prec = 3'd7; in_last = 1'b1; in_valid = 1'b1;
        @(negedge clk);
        in_valid = 1'b0; in_last = 1'b0; acc_clr = 1'b1; w_load = 1'b1;
        @(negedge clk);
        acc_clr = 1'b0; w_load = 1'b0;
        chk("midrun busy", busy, 1);
        #2 rst = 1'b1;
        #1;
        model_reset();
        chk("async_rst busy", busy, 0);
        chk("async_rst out_valid", out_valid, 0);
        check_cols("async_rst");
        @(negedge clk);
        rst = 1'b0;
        #1;
        chk("post_rst in_ready", in_ready, 1);
        chk("post_rst busy", busy, 0);
        send_op(77, 7, 1'b1, 1'b0, 1'b0, 1'b0, "post_rst_w0");

        // Randomized operands
        for (int i = 0; i < 60; i++) begin
            if ($urandom_range(0, 3) == 0) rand_w();
            x = int'($urandom_range(0, 255)) - 128;
            p = int'($urandom_range(0, 7));
            send_op(x, p, 1'($urandom_range(0, 1)), ($urandom_range(0, 7) == 0),
                    ($urandom_range(0, 3) == 0), 1'b0, $sformatf("rand%0d", i));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/utemporal_row_mac.md
UTEMPORAL_ROW_MAC -- requirements
Module: utemporal_row_mac

Interface
REQ-001 Parameter WIDTH, default 14: number of weight-stationary columns in the row.
REQ-002 Parameter IWIDTH, default 8: signed ifm width; weight magnitude is IWIDTH-1 bits.
REQ-003 Parameter OWIDTH, default 16: signed accumulator/ofm width.
REQ-004 Parameter PWIDTH, default 3: width of prec; legal prec values are 1..IWIDTH-1.
REQ-005 One clock; reset is asynchronous and active-high.
REQ-006 clk  in  1  rising-edge clock.
REQ-007 rst  in  1  asynchronous active-high reset.
REQ-008 w_load  in  1  latch wght_sign/wght_abs for all columns.
REQ-009 wght_sign  in  1 x WIDTH  per-column weight sign, 1 = negative.
REQ-010 wght_abs  in  (IWIDTH-1) x WIDTH  per-column weight magnitude, unsigned.
REQ-011 prec  in  PWIDTH  number of ifm magnitude MSBs used; sampled with each operand.
REQ-012 in_valid  in  1  ifm operand offered.
REQ-013 in_last  in  1  operand is last of the dot product; qualified by in_valid.
REQ-014 ifm  in  IWIDTH  signed ifm operand.
REQ-015 in_ready  out  1  high only in IDLE.
REQ-016 acc_clr  in  1  zero all accumulators and sat flags.
REQ-017 busy  out  1  high in RUN.
REQ-018 out_valid  out  1  one-cycle pulse when ofm holds a finished dot product.
REQ-019 ofm  out  signed OWIDTH x WIDTH  per-column accumulator value, always visible.
REQ-020 sat  out  1 x WIDTH  sticky per-column saturation flag.

Function
REQ-021 FSM states IDLE, RUN, DONE; transfer occurs when in_valid && in_ready.
REQ-022 On transfer: mag = min(|ifm|, 2^(IWIDTH-1)-1) (-128 clamps to 127 at IWIDTH=8); sh = IWIDTH-1-prec; N = mag >> sh; latch ifm sign, sh, N, in_last.
REQ-023 Transfer with N>0: IDLE->RUN; RUN lasts exactly N cycles, a down-counter decrementing once per cycle.
REQ-024 Each RUN cycle, column c adds (wght_abs[c] << sh), negated when ifm_sign XOR wght_sign[c], to its accumulator.
REQ-025 Result after operand: acc += sign * ((|ifm| >> sh) << sh) * wght_abs; exact product when prec = IWIDTH-1.
REQ-026 Accumulator add saturates to [-2^(OWIDTH-1), 2^(OWIDTH-1)-1]; any clip sets sat[c] until acc_clr or rst.
REQ-027 Last RUN cycle: if latched in_last, go to DONE, else go to IDLE.
REQ-028 Transfer with N=0: no accumulation; if in_last go to DONE next cycle, else stay IDLE.
REQ-029 DONE lasts one cycle with out_valid=1, then IDLE; in_ready=0 in DONE.
REQ-030 Operand-to-out_valid latency for last operand: N+1 cycles after transfer cycle (1 when N=0).
REQ-031 w_load is honoured only in IDLE and DONE; in RUN it is ignored, and weights stay stable.
REQ-032 acc_clr is honoured only in IDLE/DONE; ignored in RUN; acc_clr with a same-cycle transfer clears first, and the new operand accumulates from zero.
REQ-033 w_load with a same-cycle transfer: the new weights are used for that operand.
REQ-034 prec of 0 or >IWIDTH-1 is treated as IWIDTH-1.
REQ-035 ofm holds its value between operands and after DONE until acc_clr.

Reset
REQ-036 rst asserted asynchronously forces IDLE, counter 0, all accumulators 0, weights 0, sat 0, in_ready=1 (once rst deasserted), busy=0, out_valid=0; this applies mid-RUN, and the operand in flight is discarded.

Verification
REQ-037 Load w: col0 +3, col1 -5; ifm=+4, last, prec=7 -> busy 4 cycles, out_valid 5 cycles after transfer, ofm0=12, ofm1=-20.
REQ-038 Two operands +2 then -3 (last), col0 w=+10 -> ofm0=-10, single out_valid, in_ready low during both RUN windows.
REQ-039 ifm=-128, w=+127, OWIDTH=16 -> mag clamps to 127, ofm=-16129, sat=0; repeat 3x without clear -> ofm=-32768, sat=1.
REQ-040 prec=3, ifm=+100, w=+1 -> N=6, sh=4, 6 busy cycles, ofm=96.
REQ-041 ifm=0 with last -> no busy cycles, out_valid next cycle, ofm unchanged.
REQ-042 rst pulse mid-RUN at cycle 2 of 10; w_load and acc_clr pulses during RUN -> after rst, all ofm=0 and FSM in IDLE; the pulses given during RUN have no effect.
